// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// ROM and registers the fetched word into IF/ID. Handles stall, branch/jump
// redirect (including one that arrives while stalled) and exception flush.
// Optional feature: define MIPS_DELAY_SLOT_EN to keep the instruction fetched
// on a redirect edge as the architectural delay slot. When it is undefined,
// that instruction is squashed.
module if_stage #(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr_out,
    output logic              rom_enable,
    input  logic [DATA_W-1:0] rom_data_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;

    // Instruction addresses are word aligned: clear the two low bits.
    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        align = {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Next-state selection: flush > stall > redirect > sequential fetch.
    always_comb begin
        pc_d          = pc_q;
        ce_d          = 1'b1;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;

        if (ce_q) begin
            if (flush) begin
                pc_d         = align(flush_pc);
                pend_valid_d = 1'b0;
                id_valid_d   = 1'b0;
                id_inst_d    = '0;
            end else if (stall) begin
                if (branch_taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = branch_target;
                end
            end else if (branch_taken || pend_valid_q) begin
                // A fresh branch outranks an older pending target.
                pc_d         = align(branch_taken ? branch_target : pend_target_q);
                pend_valid_d = 1'b0;
                id_pc_d      = pc_q;
`ifdef MIPS_DELAY_SLOT_EN
                id_inst_d    = rom_data_in;
                id_valid_d   = 1'b1;
`else
                id_inst_d    = '0;
                id_valid_d   = 1'b0;
`endif
            end else begin
                pc_d       = pc_q + ADDR_W'(4);
                id_pc_d    = pc_q;
                id_inst_d  = rom_data_in;
                id_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            ce_q          <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            id_pc_q       <= '0;
            id_inst_q     <= '0;
            id_valid_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ce_q          <= ce_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
        end
    end

    assign rom_addr_out = pc_q;
    assign rom_enable   = ce_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_valid     = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. ROM model returns address + 0x100.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr_out;
    logic        rom_enable;
    logic [31:0] rom_data_in;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int unsigned n_vec;
    int unsigned n_err;
    logic        seen_80;

`ifdef MIPS_DELAY_SLOT_EN
    localparam logic SLOT_VALID = 1'b1;
`else
    localparam logic SLOT_VALID = 1'b0;
`endif

    if_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr_out  (rom_addr_out),
        .rom_enable    (rom_enable),
        .rom_data_in   (rom_data_in),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM model.
    always_comb rom_data_in = rom_addr_out + 32'h100;

    // Track whether the discarded branch target is ever fetched.
    always @(negedge clk)
        if (rst_n && rom_enable && rom_addr_out == 32'h80) seen_80 = 1'b1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic v,
                          input logic [31:0] inst);
        check({tag, ".id_pc"}, id_pc, pc);
        check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".id_inst"}, id_inst, inst);
    endtask

    initial begin
        n_vec = 0; n_err = 0; seen_80 = 1'b0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        branch_taken = 1'b0; branch_target = '0;
        step(); step();
        rst_n = 1'b1;
        // Start-up
        check("c0.rom_enable", {31'd0, rom_enable}, 32'd0);
        check("c0.addr", rom_addr_out, 32'h0);
        chk_if("c0", 32'h0, 1'b0, 32'h0);
        step();  // edge 1: ce rises, pc holds
        check("c1.rom_enable", {31'd0, rom_enable}, 32'd1);
        check("c1.addr", rom_addr_out, 32'h0);
        check("c1.id_valid", {31'd0, id_valid}, 32'd0);
        step();  // edge 2
        check("c2.addr", rom_addr_out, 32'h4);
        chk_if("c2", 32'h0, 1'b1, 32'h100);
        step();  // edge 3
        check("c3.addr", rom_addr_out, 32'h8);
        chk_if("c3", 32'h4, 1'b1, 32'h104);
        // Stall three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", rom_addr_out, 32'h8);
            chk_if("stall", 32'h4, 1'b1, 32'h104);
        end
        stall = 1'b0;
        step();
        check("unstall.addr", rom_addr_out, 32'hC);
        chk_if("unstall", 32'h8, 1'b1, 32'h108);
        // Branch at pc=12
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        check("br.addr", rom_addr_out, 32'h40);
        chk_if("br", 32'hC, SLOT_VALID, SLOT_VALID ? 32'h10C : 32'h0);
        step();
        check("br2.addr", rom_addr_out, 32'h44);
        chk_if("br2", 32'h40, 1'b1, 32'h140);
        // Branch during stall: 0x80 then 0x90
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        step();
        check("bds1.addr", rom_addr_out, 32'h44);
        branch_target = 32'h90;
        step();
        check("bds2.addr", rom_addr_out, 32'h44);
        branch_taken = 1'b0;
        step();
        check("bds3.addr", rom_addr_out, 32'h44);
        chk_if("bds3", 32'h40, 1'b1, 32'h140);
        stall = 1'b0;
        step();
        check("bds.redirect", rom_addr_out, 32'h90);
        chk_if("bds", 32'h44, SLOT_VALID, SLOT_VALID ? 32'h144 : 32'h0);
        step();
        check("bds.next", rom_addr_out, 32'h94);
        chk_if("bds.next", 32'h90, 1'b1, 32'h190);
        // Flush precedence over stall and branch
        flush = 1'b1; stall = 1'b1; branch_taken = 1'b1;
        branch_target = 32'h200; flush_pc = 32'h180;
        step();
        flush = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        check("fl.addr", rom_addr_out, 32'h180);
        chk_if("fl", 32'h90, 1'b0, 32'h0);
        step();
        check("fl2.addr", rom_addr_out, 32'h184);
        chk_if("fl2", 32'h180, 1'b1, 32'h280);
        step();
        check("fl3.addr", rom_addr_out, 32'h188);
        // Misaligned target and wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        check("wr.addr", rom_addr_out, 32'hFFFF_FFFC);
        step();
        check("wr2.addr", rom_addr_out, 32'h0);
        chk_if("wr2", 32'hFFFF_FFFC, 1'b1, 32'h0000_00FC);
        step();
        check("wr3.addr", rom_addr_out, 32'h4);
        check("no_80_fetch", {31'd0, seen_80}, 32'd0);
        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.addr", rom_addr_out, 32'h0);
        check("rst.id_valid", {31'd0, id_valid}, 32'd0);
        check("rst.rom_enable", {31'd0, rom_enable}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS core. It owns the program counter, drives the instruction ROM's address and chip-enable, and captures the returned instruction into the IF/ID pipeline register for the decode stage. It handles:
- pipeline stall;
- branch/jump redirect, including a redirect that arrives while the pipeline is stalled;
- exception flush.

The instruction ROM is combinational: data for `rom_addr_out` is valid in the same cycle.

## Interface
Parameters:
- `ADDR_W`, default `INST_ADDR_WIDTH` (32): PC / ROM address width.
- `DATA_W`, default `INST_DATA_WIDTH` (32): instruction width.
- `RESET_PC`, default 32'h0000_0000: first fetch address.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — core clock, all state updates on rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `rom_addr_out`  out  ADDR_W  — current PC, to instruction ROM.
- `rom_enable`  out  1  — ROM chip-enable.
- `rom_data_in`  in  DATA_W  — instruction at `rom_addr_out`.
- `stall`  in  1  — hold PC and IF/ID.
- `flush`  in  1  — exception flush.
- `flush_pc`  in  ADDR_W  — handler address used on flush.
- `branch_taken`  in  1  — redirect request from decode.
- `branch_target`  in  ADDR_W  — redirect address.
- `id_pc`  out  ADDR_W  — PC of the instruction in IF/ID.
- `id_inst`  out  DATA_W  — instruction in IF/ID; 0 (NOP) when invalid.
- `id_valid`  out  1  — IF/ID holds a real instruction.

## Operation
- State: `pc`, `ce` (drives `rom_enable`), `pend_valid`, `pend_target`, and the IF/ID registers.
- Reset: `pc`=RESET_PC, `ce`=0, `pend_valid`=0, `pend_target`=0, `id_pc`=0, `id_inst`=0, `id_valid`=0.
- `ce` goes to 1 on the first rising edge after reset release and stays 1. While `ce`=0, `pc` holds and IF/ID stays invalid.
- All loaded targets have bits [1:0] forced to 0. `pc`+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC → 0).

Per-edge priority when `ce`=1:
1. **flush.** `pc`←`flush_pc`, `pend_valid`←0, `id_valid`←0, `id_inst`←0. `id_pc` holds. Flush overrides `stall` and `branch_taken`.
2. **stall.** `pc` and IF/ID hold. If `branch_taken`=1: `pend_valid`←1, `pend_target`←`branch_target`. A later branch during the same stall overwrites the pending target.
3. **Not stalled, redirect.** Applies when `branch_taken`=1 or `pend_valid`=1. `pc`←`branch_target` if `branch_taken`, else `pend_target`; `pend_valid`←0. IF/ID loads the current fetch according to the delay-slot rule (see Configuration).
4. **Otherwise.** `pc`←`pc`+4; `id_pc`←`pc`, `id_inst`←`rom_data_in`, `id_valid`←1.

Reset asserted mid-operation clears all state immediately (asynchronous), including any pending redirect.

## Timing
- Fetch-to-decode latency: 1 cycle. The instruction at `pc` in cycle N appears on `id_inst` in cycle N+1.
- Redirect: the target address appears on `rom_addr_out` 1 cycle after the unstalled `branch_taken`. A pending redirect takes effect on the first edge with `stall`=0.
- Flush: `flush_pc` appears on `rom_addr_out` the next cycle, and `id_valid` is 0 that same cycle.
- No combinational path from `rom_data_in`, `stall`, `flush` or `branch_*` to any output. All outputs are registered.

## Configuration
- `MIPS_DELAY_SLOT_EN`
  - Defined: on a redirect edge (rule 3), the fetched instruction is the architectural delay slot. IF/ID loads `id_pc`←`pc`, `id_inst`←`rom_data_in`, `id_valid`←1.
  - Undefined: on a redirect edge, IF/ID is squashed. `id_valid`←0, `id_inst`←0, `id_pc`←`pc`.

## Test plan
- **Reset and start-up.** Release `rst_n`, ROM returns addr+32'h100. Required:
  - cycle 0: `rom_enable`=0, `rom_addr_out`=0;
  - cycle 1: `rom_enable`=1;
  - cycle 2: `id_pc`=0, `id_inst`=32'h100, `id_valid`=1;
  - `rom_addr_out` steps 0→4→8.
- **Stall.** `stall`=1 for 3 cycles at `pc`=8. Required: `rom_addr_out` stays 8, IF/ID stays frozen. After release, `id_pc`=8, then 12.
- **Branch.** `branch_taken`=1, `branch_target`=32'h40 while `pc`=12. Required:
  - next `rom_addr_out`=32'h40;
  - `id_pc`=12 with `id_valid`=1 when `MIPS_DELAY_SLOT_EN` is defined, `id_valid`=0 when it is undefined.
- **Branch during stall.** `stall`=1, `branch_taken` pulses with 32'h80 and then 32'h90, then `stall`=0. Required: `rom_addr_out` stays put during the stall, becomes 32'h90 one cycle after release, and 32'h80 is never fetched.
- **Flush precedence.** `flush`=1, `stall`=1, `branch_taken`=1 in the same cycle, `flush_pc`=32'h180. Required: next `rom_addr_out`=32'h180, `id_valid`=0, `pend_valid` cleared (no later redirect).
- **Wrap and misalignment.**
  - `branch_target`=32'hFFFF_FFFE gives `rom_addr_out`=32'hFFFF_FFFC, then 0.
  - Asserting `rst_n`=0 mid-run gives `rom_addr_out`=RESET_PC and `id_valid`=0 before the next clock edge.
